nbr128_ctrl: RTL and testbench
==============================

// Module: nbr128_ctrl
// PURPOSE
//  Initiator/driver for the NBR128 bistable-ring PUF. Accepts a 128-bit challenge from a host.
//  Drives PUF_C and holds the ring in reset, then releases it and waits for the ring to settle.
//  Samples the asynchronous PUF_OUT through a synchronizer and returns a 1-bit response to the host.
//  Sits between the host/scan interface and the hard NBR128 macro.
// PARAMETERS
//  RST_CYCLES     8    cycles PUF_RESET is held high per evaluation (>=1)
//  SETTLE_CYCLES  256  cycles after PUF_RESET release before sampling (>=3, covers sync depth)
//  NUM_EVAL       5    evaluations per challenge; odd, >=1; used only with NBR_MAJORITY_VOTE_EN
// PORTS
//  CLK         in   1    single clock; all state on rising edge
//  RESET_N     in   1    asynchronous active-low reset
//  CHAL        in   128  challenge from host
//  CHAL_VALID  in   1    host challenge valid
//  CHAL_READY  out  1    controller ready; accept on CHAL_VALID&&CHAL_READY at rising edge
//  RESP        out  1    PUF response bit
//  RESP_VALID  out  1    response valid; RESP held stable until accepted
//  RESP_READY  in   1    host accepts response when RESP_VALID&&RESP_READY
//  BUSY        out  1    evaluation in progress (accept edge through response handshake)
//  PUF_RESET   out  1    to NBR128 RESET; 1 = ring held in reset
//  PUF_C       out  128  to NBR128 C
//  PUF_OUT     in   1    from NBR128 OUT; asynchronous; passes through a 2-flop sync
// BEHAVIOUR
//  - All outputs are registered. Reset values: CHAL_READY=0, RESP=0, RESP_VALID=0, BUSY=0, PUF_RESET=1, PUF_C=0.
//  - FSM states: IDLE -> RST -> SETTLE -> (RST if more evals) -> DONE -> IDLE.
//  - IDLE: CHAL_READY=1 from the first edge after RESET_N deasserts. PUF_RESET=1.
//  - Accept at edge T: PUF_C<=CHAL, CHAL_READY<=0, BUSY<=1. PUF_RESET stays 1.
//  - RST occupies edges T+1..T+RST_CYCLES. PUF_C is stable for the whole of RST.
//  - PUF_RESET<=0 at T+RST_CYCLES+1. SETTLE lasts SETTLE_CYCLES cycles.
//  - On the final SETTLE edge, capture the synchronized PUF_OUT. Also set PUF_RESET<=1 (park the ring).
//  - Single evaluation: RESP_VALID=1 at edge T+1+RST_CYCLES+SETTLE_CYCLES (T+265 at defaults).
//  - DONE: RESP and RESP_VALID hold until RESP_READY. On the handshake edge RESP_VALID<=0, BUSY<=0.
//    CHAL_READY<=1 on the next edge, so a new challenge is never accepted on the handshake edge.
//  - If RESP_READY is already high, RESP_VALID lasts exactly 1 cycle.
//  - CHAL_VALID is ignored while BUSY. CHAL changes after the accept edge have no effect on PUF_C.
//  - The sync flops free-run. PUF_OUT is never sampled outside the final SETTLE edge.
//  - Counters are sized $clog2(max(RST_CYCLES,SETTLE_CYCLES)+1) and reload to 0 on every state entry.
//  - RESET_N asserted mid-operation: all outputs go to reset values immediately and asynchronously.
//    The in-flight response is discarded and the FSM returns to IDLE. RESP_VALID is never seen.
// CONFIGURATION
//  NBR_MAJORITY_VOTE_EN defined:
//   - Each challenge runs NUM_EVAL RST+SETTLE evaluations back-to-back with the same PUF_C.
//   - Each evaluation's sample adds to a ones counter of width $clog2(NUM_EVAL+1).
//   - RESP = (ones > NUM_EVAL/2).
//   - RESP_VALID at edge T+1+NUM_EVAL*(RST_CYCLES+SETTLE_CYCLES).
//   - The ones counter clears on accept.
//  NBR_MAJORITY_VOTE_EN undefined:
//   - One evaluation only. NUM_EVAL is ignored.
//   - RESP is the single sample. No vote logic is synthesized.
// TESTING
//  1. Assert RESET_N=0, then release. -> During reset PUF_RESET=1, PUF_C=0, RESP_VALID=0, BUSY=0.
//     CHAL_READY=1 one edge after release.
//  2. CHAL=128'hA5A5...A5, PUF_OUT=1, RESP_READY=1, accept at T.
//     -> PUF_C=CHAL and PUF_RESET=1 for T+1..T+8; PUF_RESET=0 from T+9. RESP=1, RESP_VALID=1 at T+265 for 1 cycle.
//  3. Same as 2 with RESP_READY=0 for 20 cycles after RESP_VALID; toggle PUF_OUT.
//     -> RESP constant, PUF_RESET=1, CHAL_READY=0. CHAL_READY=1 one edge after the handshake.
//  4. During SETTLE, assert CHAL_VALID with CHAL=0. -> No accept; PUF_C unchanged; BUSY stays 1.
//  5. Drop RESET_N at T+100 (mid-SETTLE). -> Immediate reset values. No RESP_VALID until a new accept.
//  6. NBR_MAJORITY_VOTE_EN, NUM_EVAL=5, PUF_OUT per evaluation = 1,0,1,1,0.
//     -> RESP=1, RESP_VALID at T+1+5*264 = T+1321. Pattern 0,0,1,0,1 -> RESP=0.

Source files
------------

// File: rtl/nbr128_ctrl.sv
// rtl/nbr128_ctrl.sv - NBR128 bistable-ring PUF challenge/response controller
// Build macro NBR_MAJORITY_VOTE_EN: run NUM_EVAL evaluations per challenge and majority-vote the response.
// Ports:
//   CLK, RESET_N                     single clock, asynchronous active-low reset
//   CHAL[127:0], CHAL_VALID/READY    host challenge handshake
//   RESP, RESP_VALID/READY           host response handshake (RESP held until accepted)
//   BUSY                             high from accept edge through response handshake
//   PUF_RESET, PUF_C[127:0]          ring reset and challenge to the NBR128 macro
//   PUF_OUT                          asynchronous ring output, 2-flop synchronized
module nbr128_ctrl #(
  parameter int RST_CYCLES    = 8,
  parameter int SETTLE_CYCLES = 256,
  parameter int NUM_EVAL      = 5
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic [127:0] CHAL,
  input  logic         CHAL_VALID,
  output logic         CHAL_READY,
  output logic         RESP,
  output logic         RESP_VALID,
  input  logic         RESP_READY,
  output logic         BUSY,
  output logic         PUF_RESET,
  output logic [127:0] PUF_C,
  input  logic         PUF_OUT
);

  localparam int CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  if (RST_CYCLES < 1) begin : g_bad_rst_cycles
    $error("nbr128_ctrl: RST_CYCLES must be at least 1");
  end
  if (SETTLE_CYCLES < 3) begin : g_bad_settle_cycles
    $error("nbr128_ctrl: SETTLE_CYCLES must be at least 3");
  end
  if ((NUM_EVAL < 1) || ((NUM_EVAL % 2) == 0)) begin : g_bad_num_eval
    $error("nbr128_ctrl: NUM_EVAL must be odd and at least 1");
  end

  typedef enum logic [1:0] {IDLE, RST, SETTLE, DONE} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            chal_ready_d, busy_d, puf_reset_d, resp_d, resp_valid_d;
  logic [127:0]    puf_c_d;
  logic [1:0]      puf_sync;
  logic            accept, rst_done, settle_done, last_eval, vote;

  assign accept      = (state == IDLE) && CHAL_READY && CHAL_VALID;
  assign rst_done    = (state == RST) && (cnt == CW'(RST_CYCLES - 1));
  assign settle_done = (state == SETTLE) && (cnt == CW'(SETTLE_CYCLES - 1));

  // Free-running synchronizer; only its output at settle_done is ever used.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) puf_sync <= 2'b00;
    else          puf_sync <= {puf_sync[0], PUF_OUT};
  end

`ifdef NBR_MAJORITY_VOTE_EN
  localparam int EW = $clog2(NUM_EVAL + 1);

  logic [EW-1:0] eval_cnt, ones_cnt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      eval_cnt <= '0;
      ones_cnt <= '0;
    end else if (accept) begin
      eval_cnt <= '0;
      ones_cnt <= '0;
    end else if (settle_done) begin
      eval_cnt <= eval_cnt + EW'(1);
      ones_cnt <= ones_cnt + EW'(puf_sync[1]);
    end
  end

  assign last_eval = (eval_cnt == EW'(NUM_EVAL - 1));
  assign vote      = (ones_cnt > EW'(NUM_EVAL / 2));
`else
  logic sample_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)         sample_q <= 1'b0;
    else if (settle_done) sample_q <= puf_sync[1];
  end

  assign last_eval = 1'b1;
  assign vote      = sample_q;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      cnt        <= '0;
      CHAL_READY <= 1'b0;
      BUSY       <= 1'b0;
      PUF_RESET  <= 1'b1;
      PUF_C      <= '0;
      RESP       <= 1'b0;
      RESP_VALID <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      CHAL_READY <= chal_ready_d;
      BUSY       <= busy_d;
      PUF_RESET  <= puf_reset_d;
      PUF_C      <= puf_c_d;
      RESP       <= resp_d;
      RESP_VALID <= resp_valid_d;
    end
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt + CW'(1);
    chal_ready_d = CHAL_READY;
    busy_d       = BUSY;
    puf_reset_d  = PUF_RESET;
    puf_c_d      = PUF_C;
    resp_d       = RESP;
    resp_valid_d = RESP_VALID;

    unique case (state)
      IDLE: begin
        cnt_d        = '0;
        puf_reset_d  = 1'b1;
        chal_ready_d = 1'b1;
        if (accept) begin
          puf_c_d      = CHAL;
          chal_ready_d = 1'b0;
          busy_d       = 1'b1;
          state_d      = RST;
        end
      end
      RST: begin
        puf_reset_d = 1'b1;
        if (rst_done) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        puf_reset_d = 1'b0;
        if (settle_done) begin
          // Park the ring as soon as the sample is taken.
          puf_reset_d = 1'b1;
          cnt_d       = '0;
          state_d     = last_eval ? DONE : RST;
        end
      end
      DONE: begin
        cnt_d       = '0;
        puf_reset_d = 1'b1;
        // First DONE edge publishes the response; RESP_VALID is therefore
        // already high whenever a handshake is recognised here.
        if (!RESP_VALID) begin
          resp_valid_d = 1'b1;
          resp_d       = vote;
        end else if (RESP_READY) begin
          resp_valid_d = 1'b0;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_nbr128_ctrl.sv
// tb/tb_nbr128_ctrl.sv - randomized self-checking bench for nbr128_ctrl
module tb_nbr128_ctrl;

  localparam int RST_C = 8;
  localparam int SET_C = 256;
  localparam int NEV   = 5;
  localparam int P     = RST_C + SET_C;
`ifdef NBR_MAJORITY_VOTE_EN
  localparam int E = NEV;
`else
  localparam int E = 1;
`endif

  logic         CLK = 1'b0;
  logic         RESET_N;
  logic [127:0] CHAL;
  logic         CHAL_VALID;
  logic         CHAL_READY;
  logic         RESP;
  logic         RESP_VALID;
  logic         RESP_READY;
  logic         BUSY;
  logic         PUF_RESET;
  logic [127:0] PUF_C;
  logic         PUF_OUT;

  int n_checks = 0;
  int n_pass   = 0;

  nbr128_ctrl #(
    .RST_CYCLES(RST_C),
    .SETTLE_CYCLES(SET_C),
    .NUM_EVAL(NEV)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .CHAL(CHAL),
    .CHAL_VALID(CHAL_VALID),
    .CHAL_READY(CHAL_READY),
    .RESP(RESP),
    .RESP_VALID(RESP_VALID),
    .RESP_READY(RESP_READY),
    .BUSY(BUSY),
    .PUF_RESET(PUF_RESET),
    .PUF_C(PUF_C),
    .PUF_OUT(PUF_OUT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #(600_000);
    $display("FAIL watchdog: still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: response is the majority of the per-evaluation ring outputs,
  // published one cycle after E full reset+settle periods.
  function automatic logic model_resp(input logic [31:0] bits);
    int ones = 0;
    for (int k = 0; k < E; k++) ones += int'(bits[k]);
    return (2 * ones > E);
  endfunction

  task automatic run_txn(input logic [127:0] chal, input logic [31:0] bits,
                         input int rdy_delay, input string name);
    int lat = 1 + E * P;
    logic exp_resp = model_resp(bits);
    int w = 0;
    int bad_c = 0, bad_b = 0, bad_rdy = 0, bad_r = 0, bad_v = 0, bad_h = 0;

    RESP_READY = (rdy_delay == 0);
    CHAL_VALID = 1'b0;
    while (CHAL_READY !== 1'b1 && w < 10) begin
      tick();
      w++;
    end
    n_checks++;
    if (CHAL_READY !== 1'b1) begin
      $display("FAIL %s wait_ready: chal_ready=%b, want 1 within 10 cycles", name, CHAL_READY);
      return;
    end else n_pass++;

    CHAL = chal;
    CHAL_VALID = 1'b1;
    tick();  // accept edge T
    CHAL_VALID = 1'b0;
    n_checks++;
    if (CHAL_READY !== 1'b0 || BUSY !== 1'b1 || PUF_C !== chal || PUF_RESET !== 1'b1)
      $display("FAIL %s accept: ready=%b busy=%b puf_reset=%b puf_c_ok=%b, want 0 1 1 1",
               name, CHAL_READY, BUSY, PUF_RESET, PUF_C === chal);
    else n_pass++;

    for (int i = 1; i <= lat; i++) begin
      int q = i - 1;
      int o;
      logic exp_pr;
      if (q < E * P && (q % P) >= P - 10) PUF_OUT = bits[q / P];
      else PUF_OUT = 1'($urandom_range(0, 1));
      CHAL       = rand128();
      CHAL_VALID = 1'($urandom_range(0, 1));
      tick();
      if (PUF_C !== chal) bad_c++;
      if (BUSY !== 1'b1) bad_b++;
      if (CHAL_READY !== 1'b0) bad_rdy++;
      o = (i - 1) % P + 1;
      exp_pr = (i > E * P) || (o <= RST_C) || (o == P);
      if (PUF_RESET !== exp_pr) bad_r++;
      if (i < lat && RESP_VALID !== 1'b0) bad_v++;
    end

    n_checks++;
    if (bad_c != 0) $display("FAIL %s puf_c_stable: %0d bad cycles, want 0", name, bad_c);
    else n_pass++;
    n_checks++;
    if (bad_b != 0 || bad_rdy != 0)
      $display("FAIL %s busy_ready: %0d busy and %0d ready errors, want 0", name, bad_b, bad_rdy);
    else n_pass++;
    n_checks++;
    if (bad_r != 0) $display("FAIL %s puf_reset_profile: %0d bad cycles, want 0", name, bad_r);
    else n_pass++;
    n_checks++;
    if (bad_v != 0) $display("FAIL %s early_resp_valid: %0d cycles, want 0", name, bad_v);
    else n_pass++;
    n_checks++;
    if (RESP_VALID !== 1'b1) $display("FAIL %s resp_valid_latency: got %b at T+%0d, want 1", name, RESP_VALID, lat);
    else n_pass++;
    n_checks++;
    if (RESP !== exp_resp) $display("FAIL %s resp: got %b, want %b", name, RESP, exp_resp);
    else n_pass++;

    for (int c = 0; c < rdy_delay; c++) begin
      PUF_OUT    = 1'($urandom_range(0, 1));
      CHAL       = rand128();
      CHAL_VALID = 1'($urandom_range(0, 1));
      tick();
      if (RESP_VALID !== 1'b1 || RESP !== exp_resp || PUF_RESET !== 1'b1 ||
          CHAL_READY !== 1'b0 || BUSY !== 1'b1) bad_h++;
    end
    n_checks++;
    if (bad_h != 0) $display("FAIL %s resp_hold: %0d bad cycles, want 0", name, bad_h);
    else n_pass++;

    CHAL_VALID = 1'b0;
    RESP_READY = 1'b1;
    tick();  // handshake edge
    n_checks++;
    if (RESP_VALID !== 1'b0 || BUSY !== 1'b0 || CHAL_READY !== 1'b0)
      $display("FAIL %s handshake: valid=%b busy=%b ready=%b, want 0 0 0", name, RESP_VALID, BUSY, CHAL_READY);
    else n_pass++;
    RESP_READY = 1'b0;
    tick();
    n_checks++;
    if (CHAL_READY !== 1'b1) $display("FAIL %s ready_after_handshake: got %b, want 1", name, CHAL_READY);
    else n_pass++;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (PUF_RESET !== 1'b1 || PUF_C !== 128'd0 || RESP_VALID !== 1'b0 || BUSY !== 1'b0 ||
        CHAL_READY !== 1'b0 || RESP !== 1'b0)
      $display("FAIL reset_values: puf_reset=%b puf_c=%h valid=%b busy=%b ready=%b resp=%b, want 1 0 0 0 0 0",
               PUF_RESET, PUF_C, RESP_VALID, BUSY, CHAL_READY, RESP);
    else n_pass++;
    RESET_N = 1'b1;
    #1;
    n_checks++;
    if (CHAL_READY !== 1'b0) $display("FAIL reset_release_ready: got %b, want 0 before first edge", CHAL_READY);
    else n_pass++;
    tick();
    n_checks++;
    if (CHAL_READY !== 1'b1 || PUF_RESET !== 1'b1)
      $display("FAIL reset_first_edge: ready=%b puf_reset=%b, want 1 1", CHAL_READY, PUF_RESET);
    else n_pass++;
  endtask

  task automatic test_single_eval();
    run_txn({16{8'hA5}}, 32'hFFFF_FFFF, 0, "a5_ones");
  endtask

  task automatic test_resp_hold();
    run_txn(rand128(), 32'hFFFF_FFFF, 20, "resp_hold");
  endtask

  task automatic test_mid_reset();
    int bad = 0;
    CHAL = rand128();
    CHAL_VALID = 1'b1;
    tick();
    CHAL_VALID = 1'b0;
    n_checks++;
    if (BUSY !== 1'b1) $display("FAIL mid_reset_accept: busy=%b, want 1", BUSY);
    else n_pass++;
    repeat (100) tick();
    #2;
    RESET_N = 1'b0;
    #1;
    n_checks++;
    if (PUF_RESET !== 1'b1 || PUF_C !== 128'd0 || RESP_VALID !== 1'b0 || BUSY !== 1'b0 ||
        CHAL_READY !== 1'b0 || RESP !== 1'b0)
      $display("FAIL mid_reset_async: puf_reset=%b puf_c=%h valid=%b busy=%b ready=%b, want 1 0 0 0 0",
               PUF_RESET, PUF_C, RESP_VALID, BUSY, CHAL_READY);
    else n_pass++;
    repeat (2) tick();
    RESET_N = 1'b1;
    for (int i = 0; i < 400; i++) begin
      PUF_OUT = 1'($urandom_range(0, 1));
      RESP_READY = 1'($urandom_range(0, 1));
      tick();
      if (RESP_VALID !== 1'b0 || BUSY !== 1'b0) bad++;
    end
    RESP_READY = 1'b0;
    n_checks++;
    if (bad != 0) $display("FAIL mid_reset_no_resp: %0d cycles with valid/busy, want 0", bad);
    else n_pass++;
    n_checks++;
    if (CHAL_READY !== 1'b1) $display("FAIL mid_reset_idle_ready: got %b, want 1", CHAL_READY);
    else n_pass++;
  endtask

`ifdef NBR_MAJORITY_VOTE_EN
  task automatic test_majority_vote();
    run_txn(rand128(), 32'b01101, 0, "vote_10110");
    run_txn(rand128(), 32'b10100, 2, "vote_00101");
  endtask
`endif

  task automatic test_back_to_back();
    int n = (E == 1) ? 6 : 2;
    for (int t = 0; t < n; t++)
      run_txn(rand128(), $urandom, $urandom_range(0, 5), $sformatf("random_%0d", t));
  endtask

  initial begin
    RESET_N    = 1'b0;
    CHAL       = '0;
    CHAL_VALID = 1'b0;
    RESP_READY = 1'b0;
    PUF_OUT    = 1'b0;
    test_reset();
    test_single_eval();
    test_resp_hold();
    test_mid_reset();
`ifdef NBR_MAJORITY_VOTE_EN
    test_majority_vote();
`endif
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
